// File: rtl/flt_onboard_selftest.sv
// flt_onboard_selftest
//   On-board self-test engine for the AXI4-Stream floating-point cores.
//   Streams VEC_NUM pseudo-random operands (Galois LFSR) into the core
//   under test and compresses every result it accepts into a 32-bit MISR
//   signature. At the end of a run the signature is compared against
//   EXP_SIGNATURE. A watchdog aborts the run if the core stops answering.
//
// Ports
//   i_aclk, i_areset        clock, asynchronous active-high reset
//   i_start                 start/restart pulse (ignored while running)
//   o_axi4s_a_*             operand stream towards the core
//   i_axi4s_result_*        result stream from the core
//   o_axi4s_result_tready   result acceptance (optionally toggling)
//   o_busy / o_done         running / all results received (sticky)
//   o_success               done with matching signature
//   o_timeout               watchdog fired (sticky)
//   o_signature             MISR value, frozen once the run ends
//   o_result_cnt            results accepted in this run
module flt_onboard_selftest #(
    parameter int          IN_WIDTH        = 32,
    parameter int          OUT_WIDTH       = 32,
    parameter int          TDATA_WIDTH     = ((IN_WIDTH + 7) / 8) * 8,
    parameter int          TDATA_OUT_WIDTH = ((OUT_WIDTH + 7) / 8) * 8,
    parameter int          VEC_NUM         = 1000,
    parameter logic [31:0] LFSR_SEED       = 32'h0000_0001,
    parameter logic [31:0] POLY            = 32'h8020_0003,
    parameter logic [31:0] EXP_SIGNATURE   = 32'h0000_0000,
    parameter int          TIMEOUT         = 4096,
    parameter int          BP_MODE         = 0
) (
    input  logic                       i_aclk,
    input  logic                       i_areset,
    input  logic                       i_start,
    output logic [TDATA_WIDTH-1:0]     o_axi4s_a_tdata,
    output logic                       o_axi4s_a_tvalid,
    input  logic                       i_axi4s_a_tready,
    input  logic [TDATA_OUT_WIDTH-1:0] i_axi4s_result_tdata,
    input  logic                       i_axi4s_result_tvalid,
    output logic                       o_axi4s_result_tready,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_success,
    output logic                       o_timeout,
    output logic [31:0]                o_signature,
    output logic [15:0]                o_result_cnt
);

    localparam int          FOLD_W = ((TDATA_OUT_WIDTH + 31) / 32) * 32;
    localparam int          NCHUNK = FOLD_W / 32;
    localparam logic [15:0] VEC_N  = 16'(VEC_NUM);
    localparam logic [31:0] TMO    = 32'(TIMEOUT);
    localparam logic [31:0] MISR_INIT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;

    // Galois step shared by operand generator and signature register.
    function automatic logic [31:0] step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? POLY : 32'h0);
    endfunction

    // LFSR state truncated/zero-extended to the operand width, upper tdata bits zero.
    function automatic logic [TDATA_WIDTH-1:0] to_operand(input logic [31:0] s);
        logic [TDATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < IN_WIDTH && i < 32; i++) r[i] = s[i];
        return r;
    endfunction

    // XOR of all 32-bit chunks of the zero-padded result.
    function automatic logic [31:0] fold(input logic [TDATA_OUT_WIDTH-1:0] d);
        logic [FOLD_W-1:0] p;
        logic [31:0]       acc;
        p   = '0;
        p[TDATA_OUT_WIDTH-1:0] = d;
        acc = '0;
        for (int c = 0; c < NCHUNK; c++) acc ^= p[c*32 +: 32];
        return acc;
    endfunction

    state_t                 state_q;
    logic [31:0]            lfsr_q, misr_q, sig_q, wd_q;
    logic [15:0]            sent_q, rcnt_q;
    logic [TDATA_WIDTH-1:0] tdata_q;
    logic                   tvalid_q, rready_q, busy_q, done_q, success_q, timeout_q;

    logic        a_hs, r_hs;
    logic [31:0] lfsr_d, misr_d, wd_d;
    logic [15:0] sent_d, rcnt_d;

    // rready_q/tvalid_q are only ever high in RUN, so no state qualifier needed.
    assign a_hs   = tvalid_q & i_axi4s_a_tready;
    assign r_hs   = rready_q & i_axi4s_result_tvalid;
    assign lfsr_d = step(lfsr_q);
    assign misr_d = step(misr_q) ^ fold(i_axi4s_result_tdata);
    assign wd_d   = wd_q + 32'd1;
    assign sent_d = sent_q + 16'd1;
    assign rcnt_d = rcnt_q + 16'd1;

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            state_q   <= IDLE;
            lfsr_q    <= LFSR_SEED;
            misr_q    <= MISR_INIT;
            sig_q     <= '0;
            wd_q      <= '0;
            sent_q    <= '0;
            rcnt_q    <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            success_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (a_hs) begin
                        lfsr_q  <= lfsr_d;
                        tdata_q <= to_operand(lfsr_d);
                        sent_q  <= sent_d;
                        if (sent_d == VEC_N) tvalid_q <= 1'b0;
                    end
                    if (BP_MODE != 0) rready_q <= ~rready_q;
                    // Later assignments below override the toggle on run exit.
                    if (r_hs) begin
                        misr_q <= misr_d;
                        sig_q  <= misr_d;
                        rcnt_q <= rcnt_d;
                        wd_q   <= '0;
                        if (rcnt_d == VEC_N) begin
                            state_q   <= DONE;
                            busy_q    <= 1'b0;
                            rready_q  <= 1'b0;
                            tvalid_q  <= 1'b0;
                            done_q    <= 1'b1;
                            success_q <= (misr_d == EXP_SIGNATURE);
                        end
                    end else begin
                        wd_q <= wd_d;
                        if (wd_d == TMO) begin
                            state_q   <= FAIL;
                            busy_q    <= 1'b0;
                            rready_q  <= 1'b0;
                            tvalid_q  <= 1'b0;
                            timeout_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE, DONE and FAIL all (re)start a fresh run.
                    if (i_start) begin
                        state_q   <= RUN;
                        lfsr_q    <= LFSR_SEED;
                        misr_q    <= MISR_INIT;
                        sig_q     <= MISR_INIT;
                        wd_q      <= '0;
                        sent_q    <= '0;
                        rcnt_q    <= '0;
                        tdata_q   <= to_operand(LFSR_SEED);
                        tvalid_q  <= 1'b1;
                        rready_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        success_q <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_axi4s_a_tdata       = tdata_q;
    assign o_axi4s_a_tvalid      = tvalid_q;
    assign o_axi4s_result_tready = rready_q;
    assign o_busy                = busy_q;
    assign o_done                = done_q;
    assign o_success             = success_q;
    assign o_timeout             = timeout_q;
    assign o_signature           = sig_q;
    assign o_result_cnt          = rcnt_q;

endmodule

// File: tb/tb_flt_onboard_selftest.sv
// Testbench for flt_onboard_selftest. Four engine instances share clock and
// reset: 0 = main (40 vectors, 16-cycle watchdog), 1/3 = single vector with
// matching / non-matching golden signature, 2 = 1000 vectors with toggling
// result ready. Expected operands and signatures come from a reference model
// of the LFSR/MISR rules plus the bench's own record of results it sent.
module tb_flt_onboard_selftest;

    localparam int          VEC_M = 40;
    localparam logic [31:0] EXP_M = 32'hC05F_FFFC;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [3:0]         start = '0;
    logic [3:0][31:0]   a_tdata;
    logic [3:0]         a_tvalid;
    logic [3:0]         a_tready = '0;
    logic [3:0][31:0]   r_tdata = '0;
    logic [3:0]         r_tvalid = '0;
    logic [3:0]         r_tready, busy, done, success, tmo;
    logic [3:0][31:0]   sig;
    logic [3:0][15:0]   rcnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] ref_sig;

    always #5 clk = ~clk;

    flt_onboard_selftest #(.VEC_NUM(VEC_M), .EXP_SIGNATURE(EXP_M), .TIMEOUT(16)) u_main (
        .i_aclk(clk), .i_areset(rst), .i_start(start[0]),
        .o_axi4s_a_tdata(a_tdata[0]), .o_axi4s_a_tvalid(a_tvalid[0]), .i_axi4s_a_tready(a_tready[0]),
        .i_axi4s_result_tdata(r_tdata[0]), .i_axi4s_result_tvalid(r_tvalid[0]),
        .o_axi4s_result_tready(r_tready[0]), .o_busy(busy[0]), .o_done(done[0]),
        .o_success(success[0]), .o_timeout(tmo[0]), .o_signature(sig[0]), .o_result_cnt(rcnt[0]));

    flt_onboard_selftest #(.VEC_NUM(1), .EXP_SIGNATURE(32'hC05F_FFFC)) u_one_ok (
        .i_aclk(clk), .i_areset(rst), .i_start(start[1]),
        .o_axi4s_a_tdata(a_tdata[1]), .o_axi4s_a_tvalid(a_tvalid[1]), .i_axi4s_a_tready(a_tready[1]),
        .i_axi4s_result_tdata(r_tdata[1]), .i_axi4s_result_tvalid(r_tvalid[1]),
        .o_axi4s_result_tready(r_tready[1]), .o_busy(busy[1]), .o_done(done[1]),
        .o_success(success[1]), .o_timeout(tmo[1]), .o_signature(sig[1]), .o_result_cnt(rcnt[1]));

    flt_onboard_selftest #(.VEC_NUM(1000), .BP_MODE(1)) u_bp (
        .i_aclk(clk), .i_areset(rst), .i_start(start[2]),
        .o_axi4s_a_tdata(a_tdata[2]), .o_axi4s_a_tvalid(a_tvalid[2]), .i_axi4s_a_tready(a_tready[2]),
        .i_axi4s_result_tdata(r_tdata[2]), .i_axi4s_result_tvalid(r_tvalid[2]),
        .o_axi4s_result_tready(r_tready[2]), .o_busy(busy[2]), .o_done(done[2]),
        .o_success(success[2]), .o_timeout(tmo[2]), .o_signature(sig[2]), .o_result_cnt(rcnt[2]));

    flt_onboard_selftest #(.VEC_NUM(1), .EXP_SIGNATURE(32'hDEAD_BEEF)) u_one_bad (
        .i_aclk(clk), .i_areset(rst), .i_start(start[3]),
        .o_axi4s_a_tdata(a_tdata[3]), .o_axi4s_a_tvalid(a_tvalid[3]), .i_axi4s_a_tready(a_tready[3]),
        .i_axi4s_result_tdata(r_tdata[3]), .i_axi4s_result_tvalid(r_tvalid[3]),
        .o_axi4s_result_tready(r_tready[3]), .o_busy(busy[3]), .o_done(done[3]),
        .o_success(success[3]), .o_timeout(tmo[3]), .o_signature(sig[3]), .o_result_cnt(rcnt[3]));

    // Reference rule: Galois step with the default polynomial.
    function automatic logic [31:0] gstep(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Behaviour of the emulated core: a fixed hash of the operand.
    function automatic logic [31:0] core_fn(input logic [31:0] x);
        return x * 32'h9E37_79B1 + 32'h7;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
    endtask

    // Emulated core on instance 0. pass=1: zero-latency pass-through, else a
    // FIFO with random latency. Stops after stop_after results or VEC_M.
    task automatic drive_run(input bit pass, input int stop_after, output logic [31:0] msig);
        logic [31:0] exp_op, prev_d;
        logic [31:0] q[$];
        bit          prev_stall, ahs, rhs;
        int          got, idle, cyc;
        exp_op = 32'h1; msig = 32'hFFFF_FFFF;
        got = 0; idle = 0; cyc = 0; prev_stall = 0; prev_d = '0;
        while (got < stop_after && got < VEC_M && cyc < 5000) begin
            if (prev_stall) begin
                n_cmp++;
                if (a_tvalid[0] !== 1'b1 || a_tdata[0] !== prev_d) begin
                    n_err++;
                    $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", a_tvalid[0], a_tdata[0], prev_d);
                end
            end
            if (pass) begin
                a_tready[0] = r_tready[0] && (($urandom % 10) < 7 || idle >= 8);
                r_tvalid[0] = a_tvalid[0] && a_tready[0];
                r_tdata[0]  = core_fn(a_tdata[0]);
            end else begin
                a_tready[0] = ($urandom % 10) < 7 || idle >= 8;
                r_tvalid[0] = (q.size() > 0) && (($urandom % 10) < 6 || idle >= 8);
                r_tdata[0]  = (q.size() > 0) ? core_fn(q[0]) : $urandom;
            end
            ahs = a_tvalid[0] && a_tready[0];
            rhs = r_tvalid[0] && r_tready[0];
            if (ahs) begin
                n_cmp++;
                if (a_tdata[0] !== exp_op) begin
                    n_err++;
                    $display("FAIL operand: got %h, required %h", a_tdata[0], exp_op);
                end
                q.push_back(a_tdata[0]);
                exp_op = gstep(exp_op);
            end
            if (rhs) begin
                msig = gstep(msig) ^ r_tdata[0];
                got++;
                idle = 0;
                void'(q.pop_front());
            end else begin
                idle++;
            end
            prev_stall = a_tvalid[0] && !a_tready[0];
            prev_d = a_tdata[0];
            tick();
            cyc++;
        end
        a_tready[0] = 1'b0;
        r_tvalid[0] = 1'b0;
        if (cyc >= 5000) begin
            n_cmp++; n_err++;
            $display("FAIL run_bound: results %0d, required %0d", got, stop_after);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({a_tdata[i], a_tvalid[i], r_tready[i], busy[i], done[i], success[i], tmo[i], sig[i], rcnt[i]} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs inst%0d: sig=%h cnt=%0d busy=%b valid=%b, required all zero", i, sig[i], rcnt[i], busy[i], a_tvalid[i]);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_random_run();
        logic [31:0] ms;
        pulse_start(0);
        n_cmp++;
        if (a_tvalid[0] !== 1'b1 || a_tdata[0] !== 32'h1 || busy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL start_edge: valid=%b data=%h busy=%b, required 1/00000001/1", a_tvalid[0], a_tdata[0], busy[0]);
        end
        drive_run(1'b0, VEC_M, ms);
        ref_sig = ms;
        n_cmp++;
        if (done[0] !== 1'b1 || busy[0] !== 1'b0 || rcnt[0] !== 16'(VEC_M)) begin
            n_err++;
            $display("FAIL run_done: done=%b busy=%b cnt=%0d, required 1/0/%0d", done[0], busy[0], rcnt[0], VEC_M);
        end
        n_cmp++;
        if (sig[0] !== ms || success[0] !== (ms == EXP_M)) begin
            n_err++;
            $display("FAIL run_sig: sig=%h succ=%b, required %h/%b", sig[0], success[0], ms, ms == EXP_M);
        end
        n_cmp++;
        if (a_tvalid[0] !== 1'b0 || r_tready[0] !== 1'b0) begin
            n_err++;
            $display("FAIL run_idle_hs: a_tvalid=%b r_tready=%b, required 0/0", a_tvalid[0], r_tready[0]);
        end
        // results offered in DONE must be ignored
        r_tvalid[0] = 1'b1; r_tdata[0] = 32'h1234_5678;
        repeat (3) tick();
        r_tvalid[0] = 1'b0;
        n_cmp++;
        if (sig[0] !== ms || rcnt[0] !== 16'(VEC_M)) begin
            n_err++;
            $display("FAIL done_frozen: sig=%h cnt=%0d, required %h/%0d", sig[0], rcnt[0], ms, VEC_M);
        end
    endtask

    task automatic test_passthrough();
        logic [31:0] ms;
        pulse_start(0);
        drive_run(1'b1, VEC_M, ms);
        n_cmp++;
        if (done[0] !== 1'b1 || sig[0] !== ms) begin
            n_err++;
            $display("FAIL pass_sig: done=%b sig=%h, required 1/%h", done[0], sig[0], ms);
        end
        n_cmp++;
        if (sig[0] !== ref_sig) begin
            n_err++;
            $display("FAIL pass_vs_fifo: sig=%h, required %h", sig[0], ref_sig);
        end
    endtask

    task automatic test_stall_timeout();
        int nb;
        logic [31:0] ms;
        nb = 0;
        pulse_start(0);
        a_tready[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (a_tvalid[0] !== 1'b1 || a_tdata[0] !== 32'h1) begin
                n_err++;
                $display("FAIL stall%0d: valid=%b data=%h, required 1/00000001", k, a_tvalid[0], a_tdata[0]);
            end
            if (busy[0]) nb++;
            tick();
        end
        a_tready[0] = 1'b1;
        if (busy[0]) nb++;
        tick();
        a_tready[0] = 1'b0;
        n_cmp++;
        if (a_tvalid[0] !== 1'b1 || a_tdata[0] !== 32'h8020_0003) begin
            n_err++;
            $display("FAIL after_stall: valid=%b data=%h, required 1/80200003", a_tvalid[0], a_tdata[0]);
        end
        for (int g = 0; g < 100 && busy[0]; g++) begin
            nb++;
            tick();
        end
        n_cmp++;
        if (nb != 16 || tmo[0] !== 1'b1 || done[0] !== 1'b0 || a_tvalid[0] !== 1'b0) begin
            n_err++;
            $display("FAIL timeout: run_cycles=%0d tmo=%b done=%b valid=%b, required 16/1/0/0", nb, tmo[0], done[0], a_tvalid[0]);
        end
        pulse_start(0);
        n_cmp++;
        if (tmo[0] !== 1'b0 || busy[0] !== 1'b1 || rcnt[0] !== 16'd0 || sig[0] !== 32'hFFFF_FFFF || a_tdata[0] !== 32'h1) begin
            n_err++;
            $display("FAIL restart: tmo=%b busy=%b cnt=%0d sig=%h data=%h, required 0/1/0/ffffffff/00000001", tmo[0], busy[0], rcnt[0], sig[0], a_tdata[0]);
        end
        drive_run(1'b0, VEC_M, ms);
        n_cmp++;
        if (done[0] !== 1'b1 || tmo[0] !== 1'b0 || sig[0] !== ref_sig) begin
            n_err++;
            $display("FAIL restart_run: done=%b tmo=%b sig=%h, required 1/0/%h", done[0], tmo[0], sig[0], ref_sig);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] ms;
        pulse_start(0);
        drive_run(1'b0, 20, ms);
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({a_tdata[0], a_tvalid[0], r_tready[0], busy[0], done[0], success[0], tmo[0], sig[0], rcnt[0]} !== '0) begin
            n_err++;
            $display("FAIL mid_reset: sig=%h cnt=%0d busy=%b valid=%b, required all zero", sig[0], rcnt[0], busy[0], a_tvalid[0]);
        end
        rst = 1'b0;
        tick();
        pulse_start(0);
        drive_run(1'b0, VEC_M, ms);
        n_cmp++;
        if (done[0] !== 1'b1 || sig[0] !== ref_sig || sig[0] !== ms) begin
            n_err++;
            $display("FAIL reset_rerun: done=%b sig=%h, required 1/%h", done[0], sig[0], ref_sig);
        end
    endtask

    task automatic test_single(input int i, input logic exp_succ);
        pulse_start(i);
        a_tready[i] = 1'b1;
        r_tvalid[i] = 1'b1;
        r_tdata[i]  = 32'h3F80_0000;
        tick();
        a_tready[i] = 1'b0;
        r_tvalid[i] = 1'b0;
        n_cmp++;
        if (sig[i] !== 32'hC05F_FFFC || done[i] !== 1'b1 || rcnt[i] !== 16'd1) begin
            n_err++;
            $display("FAIL single%0d_sig: sig=%h done=%b cnt=%0d, required c05ffffc/1/1", i, sig[i], done[i], rcnt[i]);
        end
        n_cmp++;
        if (success[i] !== exp_succ || busy[i] !== 1'b0 || a_tvalid[i] !== 1'b0) begin
            n_err++;
            $display("FAIL single%0d_flags: succ=%b busy=%b valid=%b, required %b/0/0", i, success[i], busy[i], a_tvalid[i], exp_succ);
        end
    endtask

    task automatic test_backpressure();
        int got, cyc, perr;
        logic [31:0] ms;
        got = 0; cyc = 0; perr = 0; ms = 32'hFFFF_FFFF;
        pulse_start(2);
        a_tready[2] = 1'b1;
        r_tvalid[2] = 1'b1;
        while (got < 1000 && cyc < 3000) begin
            if (r_tready[2] !== ((cyc % 2) == 0)) perr++;
            r_tdata[2] = $urandom;
            if (r_tready[2]) begin
                ms = gstep(ms) ^ r_tdata[2];
                got++;
            end
            tick();
            cyc++;
        end
        a_tready[2] = 1'b0;
        r_tvalid[2] = 1'b0;
        n_cmp++;
        if (perr != 0 || cyc != 1999) begin
            n_err++;
            $display("FAIL bp_duty: pattern_errors=%0d cycles=%0d, required 0/1999", perr, cyc);
        end
        n_cmp++;
        if (done[2] !== 1'b1 || rcnt[2] !== 16'd1000 || sig[2] !== ms || r_tready[2] !== 1'b0) begin
            n_err++;
            $display("FAIL bp_end: done=%b cnt=%0d sig=%h rdy=%b, required 1/1000/%h/0", done[2], rcnt[2], sig[2], r_tready[2], ms);
        end
    endtask

    initial begin
        test_reset();
        test_random_run();
        test_passthrough();
        test_stall_timeout();
        test_mid_reset();
        test_single(1, 1'b1);
        test_single(3, 1'b0);
        test_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
